// File: rtl/sat_subtract_pipe.sv
// sat_subtract_pipe -- pipelined multi-lane signed subtractor with optional
// rounding right shift, saturation and overflow flagging.
//   out1 = sat((in1 - in2 + 2^(OUT_SHIFT-1)) >>> OUT_SHIFT) per lane.
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   in_valid/in_ready   input handshake
//   in1, in2            CHANNELS x WIDTH signed operands, lane k at [k*WIDTH +: WIDTH]
//   out_valid/out_ready output handshake
//   out1                CHANNELS x WIDTH saturated results
//   ovf                 per-lane clip flag, aligned with out1
//   ovf_sticky          per-lane sticky overflow, set on consume of a clipped beat
//   clr_sticky          synchronous clear of sticky flags (and counters)
//   ovf_cnt             per-lane 16-bit saturating overflow counters,
//                       present only when SUB_OVF_CNT_EN is defined
module sat_subtract_pipe #(
  parameter int WIDTH     = 64,
  parameter int CHANNELS  = 1,
  parameter int OUT_SHIFT = 0
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [CHANNELS*WIDTH-1:0] in1,
  input  logic [CHANNELS*WIDTH-1:0] in2,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [CHANNELS*WIDTH-1:0] out1,
  output logic [CHANNELS-1:0]       ovf,
  output logic [CHANNELS-1:0]       ovf_sticky,
  input  logic                      clr_sticky
`ifdef SUB_OVF_CNT_EN
  ,
  output logic [CHANNELS*16-1:0]    ovf_cnt
`endif
);

  localparam int RND_SH = (OUT_SHIFT > 0) ? OUT_SHIFT - 1 : 0;
  // Rounding constant is zero when no shift is applied, so r = d falls out.
  localparam logic signed [WIDTH+1:0] RND =
    (OUT_SHIFT > 0) ? ((WIDTH+2)'(1) << RND_SH) : '0;
  localparam logic signed [WIDTH+1:0] SAT_MAX = {3'b000, {(WIDTH-1){1'b1}}};
  localparam logic signed [WIDTH+1:0] SAT_MIN = {3'b111, {(WIDTH-1){1'b0}}};

  logic                    s1_valid;
  logic                    s2_valid;
  logic                    en1;
  logic                    en2;
  logic                    consume;
  logic signed [WIDTH:0]   d_q    [CHANNELS];
  logic signed [WIDTH:0]   d_next [CHANNELS];
  logic [CHANNELS*WIDTH-1:0] sat_next;
  logic [CHANNELS-1:0]     ovf_next;
  logic [CHANNELS*WIDTH-1:0] out_q;
  logic [CHANNELS-1:0]     ovf_q;
  logic [CHANNELS-1:0]     sticky_q;

  always_comb begin
    en2       = !s2_valid || out_ready;
    en1       = !s1_valid || en2;
    in_ready  = en1;
    consume   = s2_valid && out_ready;
    out_valid = s2_valid;
    out1      = out_q;
    ovf       = ovf_q;
    ovf_sticky = sticky_q;
  end

  // Stage 1: exact difference at WIDTH+1 bits.
  always_comb begin
    for (int unsigned k = 0; k < CHANNELS; k++) begin
      d_next[k] = signed'({in1[k*WIDTH+WIDTH-1], in1[k*WIDTH +: WIDTH]})
                - signed'({in2[k*WIDTH+WIDTH-1], in2[k*WIDTH +: WIDTH]});
    end
  end

  // Stage 2: round, arithmetic shift, saturate.
  always_comb begin
    logic signed [WIDTH+1:0] t;
    logic signed [WIDTH+1:0] r;
    sat_next = '0;
    ovf_next = '0;
    for (int unsigned k = 0; k < CHANNELS; k++) begin
      t = signed'({d_q[k][WIDTH], d_q[k]}) + RND;
      r = t >>> OUT_SHIFT;
      if (r > SAT_MAX) begin
        sat_next[k*WIDTH +: WIDTH] = SAT_MAX[WIDTH-1:0];
        ovf_next[k]                = 1'b1;
      end else if (r < SAT_MIN) begin
        sat_next[k*WIDTH +: WIDTH] = SAT_MIN[WIDTH-1:0];
        ovf_next[k]                = 1'b1;
      end else begin
        sat_next[k*WIDTH +: WIDTH] = r[WIDTH-1:0];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid <= 1'b0;
      s2_valid <= 1'b0;
      out_q    <= '0;
      ovf_q    <= '0;
      for (int unsigned k = 0; k < CHANNELS; k++) d_q[k] <= '0;
    end else begin
      if (en1) begin
        s1_valid <= in_valid;
        for (int unsigned k = 0; k < CHANNELS; k++) d_q[k] <= d_next[k];
      end
      if (en2) begin
        s2_valid <= s1_valid;
        out_q    <= sat_next;
        ovf_q    <= ovf_next;
      end
    end
  end

  // Set has priority over clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sticky_q <= '0;
    end else begin
      for (int unsigned k = 0; k < CHANNELS; k++) begin
        if (consume && ovf_q[k]) sticky_q[k] <= 1'b1;
        else if (clr_sticky)     sticky_q[k] <= 1'b0;
      end
    end
  end

`ifdef SUB_OVF_CNT_EN
  logic [15:0] cnt_q [CHANNELS];

  // Clear and increment together leave the count at 1.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned k = 0; k < CHANNELS; k++) cnt_q[k] <= '0;
    end else begin
      for (int unsigned k = 0; k < CHANNELS; k++) begin
        if (clr_sticky)
          cnt_q[k] <= (consume && ovf_q[k]) ? 16'd1 : 16'd0;
        else if (consume && ovf_q[k] && cnt_q[k] != 16'hFFFF)
          cnt_q[k] <= cnt_q[k] + 16'd1;
      end
    end
  end

  always_comb begin
    ovf_cnt = '0;
    for (int unsigned k = 0; k < CHANNELS; k++) ovf_cnt[k*16 +: 16] = cnt_q[k];
  end
`endif

endmodule

// File: tb/tb_sat_subtract_pipe.sv
// Directed self-checking bench for sat_subtract_pipe. Three instances:
//   a: WIDTH=8 CHANNELS=1 OUT_SHIFT=0
//   b: WIDTH=8 CHANNELS=1 OUT_SHIFT=1
//   c: WIDTH=8 CHANNELS=2 OUT_SHIFT=0
// The overflow-counter test is built only when SUB_OVF_CNT_EN is defined.
module tb_sat_subtract_pipe;

  logic clk;
  logic rst_n;
  int   checks;
  int   errors;

  logic       a_in_valid, a_in_ready, a_out_valid, a_out_ready, a_clr;
  logic [7:0] a_in1, a_in2, a_out1;
  logic [0:0] a_ovf, a_sticky;

  logic       b_in_valid, b_in_ready, b_out_valid, b_out_ready, b_clr;
  logic [7:0] b_in1, b_in2, b_out1;
  logic [0:0] b_ovf, b_sticky;

  logic        c_in_valid, c_in_ready, c_out_valid, c_out_ready, c_clr;
  logic [15:0] c_in1, c_in2, c_out1;
  logic [1:0]  c_ovf, c_sticky;

`ifdef SUB_OVF_CNT_EN
  logic [15:0] a_cnt, b_cnt;
  logic [31:0] c_cnt;
`endif

  sat_subtract_pipe #(.WIDTH(8), .CHANNELS(1), .OUT_SHIFT(0)) u_a (
    .clk(clk), .rst_n(rst_n), .in_valid(a_in_valid), .in_ready(a_in_ready),
    .in1(a_in1), .in2(a_in2), .out_valid(a_out_valid), .out_ready(a_out_ready),
    .out1(a_out1), .ovf(a_ovf), .ovf_sticky(a_sticky), .clr_sticky(a_clr)
`ifdef SUB_OVF_CNT_EN
    , .ovf_cnt(a_cnt)
`endif
  );

  sat_subtract_pipe #(.WIDTH(8), .CHANNELS(1), .OUT_SHIFT(1)) u_b (
    .clk(clk), .rst_n(rst_n), .in_valid(b_in_valid), .in_ready(b_in_ready),
    .in1(b_in1), .in2(b_in2), .out_valid(b_out_valid), .out_ready(b_out_ready),
    .out1(b_out1), .ovf(b_ovf), .ovf_sticky(b_sticky), .clr_sticky(b_clr)
`ifdef SUB_OVF_CNT_EN
    , .ovf_cnt(b_cnt)
`endif
  );

  sat_subtract_pipe #(.WIDTH(8), .CHANNELS(2), .OUT_SHIFT(0)) u_c (
    .clk(clk), .rst_n(rst_n), .in_valid(c_in_valid), .in_ready(c_in_ready),
    .in1(c_in1), .in2(c_in2), .out_valid(c_out_valid), .out_ready(c_out_ready),
    .out1(c_out1), .ovf(c_ovf), .ovf_sticky(c_sticky), .clr_sticky(c_clr)
`ifdef SUB_OVF_CNT_EN
    , .ovf_cnt(c_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    repeat (2) tick();
    checks++; if (a_out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %b want 0", a_out_valid); end
    checks++; if (a_out1 !== 8'h00) begin errors++; $display("FAIL reset_out1 got %h want 00", a_out1); end
    checks++; if (a_ovf !== 1'b0) begin errors++; $display("FAIL reset_ovf got %b want 0", a_ovf); end
    checks++; if (a_sticky !== 1'b0) begin errors++; $display("FAIL reset_sticky got %b want 0", a_sticky); end
    rst_n = 1'b1;
    tick();
    checks++; if (a_in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got %b want 1", a_in_ready); end
    checks++; if (c_in_ready !== 1'b1) begin errors++; $display("FAIL reset_c_in_ready got %b want 1", c_in_ready); end
  endtask

  task automatic test_latency;
    a_out_ready = 1'b1;
    a_in1 = 8'd100; a_in2 = 8'd30; a_in_valid = 1'b1;
    tick();
    a_in_valid = 1'b0;
    checks++; if (a_out_valid !== 1'b0) begin errors++; $display("FAIL lat_cycle1_valid got %b want 0", a_out_valid); end
    tick();
    checks++; if (a_out_valid !== 1'b1) begin errors++; $display("FAIL lat_cycle2_valid got %b want 1", a_out_valid); end
    checks++; if (a_out1 !== 8'd70) begin errors++; $display("FAIL lat_out1 got %0d want 70", a_out1); end
    checks++; if (a_ovf !== 1'b0) begin errors++; $display("FAIL lat_ovf got %b want 0", a_ovf); end
    tick();
    checks++; if (a_out_valid !== 1'b0) begin errors++; $display("FAIL lat_drain_valid got %b want 0", a_out_valid); end
  endtask

  task automatic test_saturation;
    a_out_ready = 1'b1;
    a_in1 = 8'h7F; a_in2 = 8'hFF; a_in_valid = 1'b1;
    tick();
    a_in_valid = 1'b0;
    tick();
    checks++; if (a_out1 !== 8'h7F) begin errors++; $display("FAIL sat_pos_out1 got %h want 7f", a_out1); end
    checks++; if (a_ovf !== 1'b1) begin errors++; $display("FAIL sat_pos_ovf got %b want 1", a_ovf); end
    tick();
    checks++; if (a_sticky !== 1'b1) begin errors++; $display("FAIL sat_sticky_set got %b want 1", a_sticky); end

    a_in1 = 8'h80; a_in2 = 8'h01; a_in_valid = 1'b1;
    tick();
    a_in_valid = 1'b0;
    tick();
    checks++; if (a_out1 !== 8'h80) begin errors++; $display("FAIL sat_neg_out1 got %h want 80", a_out1); end
    checks++; if (a_ovf !== 1'b1) begin errors++; $display("FAIL sat_neg_ovf got %b want 1", a_ovf); end
    tick();

    a_clr = 1'b1;
    tick();
    a_clr = 1'b0;
    checks++; if (a_sticky !== 1'b0) begin errors++; $display("FAIL sticky_clear got %b want 0", a_sticky); end

    a_in1 = 8'h7F; a_in2 = 8'hFF; a_in_valid = 1'b1;
    tick();
    a_in_valid = 1'b0;
    tick();
    a_clr = 1'b1;
    tick();
    a_clr = 1'b0;
    checks++; if (a_sticky !== 1'b1) begin errors++; $display("FAIL sticky_set_wins got %b want 1", a_sticky); end
  endtask

  task automatic test_shift;
    logic [7:0] vin1 [4];
    logic [7:0] vin2 [4];
    logic [7:0] vexp [4];
    logic       vovf [4];
    vin1[0] = 8'd5;  vin2[0] = 8'd2;  vexp[0] = 8'd2;  vovf[0] = 1'b0;
    vin1[1] = 8'hFD; vin2[1] = 8'd0;  vexp[1] = 8'hFF; vovf[1] = 1'b0;
    vin1[2] = 8'h7F; vin2[2] = 8'h80; vexp[2] = 8'h7F; vovf[2] = 1'b1;
    vin1[3] = 8'h80; vin2[3] = 8'h7F; vexp[3] = 8'h81; vovf[3] = 1'b0;
    b_out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      b_in1 = vin1[i]; b_in2 = vin2[i]; b_in_valid = 1'b1;
      tick();
      b_in_valid = 1'b0;
      tick();
      checks++; if (b_out_valid !== 1'b1) begin errors++; $display("FAIL shift_valid[%0d] got %b want 1", i, b_out_valid); end
      checks++; if (b_out1 !== vexp[i]) begin errors++; $display("FAIL shift_out1[%0d] got %h want %h", i, b_out1, vexp[i]); end
      checks++; if (b_ovf !== vovf[i]) begin errors++; $display("FAIL shift_ovf[%0d] got %b want %b", i, b_ovf, vovf[i]); end
    end
    tick();
  endtask

  task automatic test_back_to_back;
    int          sent;
    int          recv;
    logic        m_s1, m_s2, m_en1, m_en2;
    logic        stall_prev;
    logic [15:0] held;
    logic [7:0]  v;
    logic        acc;
    sent = 0; recv = 0; m_s1 = 1'b0; m_s2 = 1'b0; stall_prev = 1'b0; held = '0;
    for (int c = 0; c < 40 && recv < 6; c++) begin
      c_out_ready = !(c >= 4 && c <= 6);
      c_in_valid  = (sent < 6);
      c_in1 = {8'(2*sent + 2), 8'(2*sent + 1)};
      c_in2 = {8'd1, 8'd0};
      #1;
      checks++;
      if (c_in_ready !== !(m_s1 && m_s2 && !c_out_ready)) begin
        errors++; $display("FAIL b2b_in_ready c%0d got %b want %b", c, c_in_ready, !(m_s1 && m_s2 && !c_out_ready));
      end
      checks++;
      if (c_out_valid !== m_s2) begin
        errors++; $display("FAIL b2b_out_valid c%0d got %b want %b", c, c_out_valid, m_s2);
      end
      if (stall_prev) begin
        checks++;
        if (c_out1 !== held) begin errors++; $display("FAIL b2b_stall_hold c%0d got %h want %h", c, c_out1, held); end
      end
      acc = c_in_valid && c_in_ready;
      if (c_out_valid && c_out_ready) begin
        v = 8'(2*recv + 1);
        checks++;
        if (c_out1 !== {v, v}) begin errors++; $display("FAIL b2b_data[%0d] got %h want %h", recv, c_out1, {v, v}); end
        recv++;
      end
      stall_prev = c_out_valid && !c_out_ready;
      held = c_out1;
      m_en2 = !m_s2 || c_out_ready;
      m_en1 = !m_s1 || m_en2;
      if (m_en2) m_s2 = m_s1;
      if (m_en1) m_s1 = c_in_valid;
      if (acc) sent++;
      tick();
    end
    c_in_valid = 1'b0;
    checks++; if (recv !== 6) begin errors++; $display("FAIL b2b_count got %0d want 6", recv); end
    tick();
    checks++; if (c_out_valid !== 1'b0) begin errors++; $display("FAIL b2b_no_dup got %b want 0", c_out_valid); end
  endtask

  task automatic test_reset_mid;
    c_out_ready = 1'b0;
    c_in1 = {8'd50, 8'd40}; c_in2 = {8'd1, 8'd1}; c_in_valid = 1'b1;
    tick();
    c_in1 = {8'd60, 8'd70};
    tick();
    c_in_valid = 1'b0;
    checks++; if (c_out_valid !== 1'b1) begin errors++; $display("FAIL rstmid_full got %b want 1", c_out_valid); end
    checks++; if (c_in_ready !== 1'b0) begin errors++; $display("FAIL rstmid_full_ready got %b want 0", c_in_ready); end
    rst_n = 1'b0;
    #1;
    checks++; if (c_out_valid !== 1'b0) begin errors++; $display("FAIL rstmid_async_valid got %b want 0", c_out_valid); end
    checks++; if (c_out1 !== 16'h0000) begin errors++; $display("FAIL rstmid_async_out1 got %h want 0000", c_out1); end
    checks++; if (c_ovf !== 2'b00) begin errors++; $display("FAIL rstmid_async_ovf got %b want 00", c_ovf); end
    tick();
    rst_n = 1'b1;
    c_out_ready = 1'b1;
    tick();
    checks++; if (c_in_ready !== 1'b1) begin errors++; $display("FAIL rstmid_ready got %b want 1", c_in_ready); end
    checks++; if (c_out_valid !== 1'b0) begin errors++; $display("FAIL rstmid_no_old got %b want 0", c_out_valid); end
    c_in1 = {8'd9, 8'd20}; c_in2 = {8'd4, 8'd3}; c_in_valid = 1'b1;
    tick();
    c_in_valid = 1'b0;
    checks++; if (c_out_valid !== 1'b0) begin errors++; $display("FAIL rstmid_lat1 got %b want 0", c_out_valid); end
    tick();
    checks++; if (c_out_valid !== 1'b1) begin errors++; $display("FAIL rstmid_lat2 got %b want 1", c_out_valid); end
    checks++; if (c_out1 !== {8'd5, 8'd17}) begin errors++; $display("FAIL rstmid_data got %h want %h", c_out1, {8'd5, 8'd17}); end
    tick();
    checks++; if (c_out_valid !== 1'b0) begin errors++; $display("FAIL rstmid_drain got %b want 0", c_out_valid); end
  endtask

`ifdef SUB_OVF_CNT_EN
  task automatic test_ovf_cnt;
    c_out_ready = 1'b1;
    c_clr = 1'b1;
    tick();
    c_clr = 1'b0;
    c_in1 = {8'd0, 8'h7F}; c_in2 = {8'd0, 8'hFF}; c_in_valid = 1'b1;
    repeat (70000) tick();
    c_in_valid = 1'b0;
    repeat (3) tick();
    checks++; if (c_cnt[15:0] !== 16'hFFFF) begin errors++; $display("FAIL cnt_lane0 got %h want ffff", c_cnt[15:0]); end
    checks++; if (c_cnt[31:16] !== 16'h0000) begin errors++; $display("FAIL cnt_lane1 got %h want 0000", c_cnt[31:16]); end
    checks++; if (c_sticky !== 2'b01) begin errors++; $display("FAIL cnt_sticky got %b want 01", c_sticky); end
    c_clr = 1'b1;
    tick();
    c_clr = 1'b0;
    checks++; if (c_cnt !== 32'h0) begin errors++; $display("FAIL cnt_clear got %h want 0", c_cnt); end
    checks++; if (c_sticky !== 2'b00) begin errors++; $display("FAIL cnt_sticky_clear got %b want 00", c_sticky); end
  endtask
`endif

  initial begin
    checks = 0; errors = 0;
    a_in_valid = 1'b0; a_out_ready = 1'b1; a_clr = 1'b0; a_in1 = '0; a_in2 = '0;
    b_in_valid = 1'b0; b_out_ready = 1'b1; b_clr = 1'b0; b_in1 = '0; b_in2 = '0;
    c_in_valid = 1'b0; c_out_ready = 1'b1; c_clr = 1'b0; c_in1 = '0; c_in2 = '0;
    test_reset();
    test_latency();
    test_saturation();
    test_shift();
    test_back_to_back();
    test_reset_mid();
`ifdef SUB_OVF_CNT_EN
    test_ovf_cnt();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
